// File: rtl/exu_lsu_axi_pkg.sv
// ============================================================================
//  Module   : lsu_pkg
//  Brief    : Shared types and encodings for the EXU load/store unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_RESP    = 3'd5
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [1:0] LSU_OK       = 2'd0;
    localparam logic [1:0] LSU_MISALIGN = 2'd1;
    localparam logic [1:0] LSU_BUSERR   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/exu_lsu_axi_if.sv
// ============================================================================
//  Module   : exu_lsu_axi_if
//  Brief    : Request/response and single-beat AXI-style channels of the LSU.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface exu_lsu_axi_if #(
    parameter int XLEN = 64,
    parameter int AW   = 64
);
    localparam int NB = XLEN / 8;

    logic            req_valid;
    logic            req_ready;
    logic            req_store;
    logic [2:0]      req_func3;
    logic [AW-1:0]   req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [4:0]      req_rd;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic [4:0]      resp_rd;
    logic [1:0]      resp_err;

    logic [AW-1:0]   aw_addr;
    logic            aw_valid;
    logic            aw_ready;
    logic [XLEN-1:0] w_data;
    logic [NB-1:0]   w_strb;
    logic            w_valid;
    logic            w_ready;
    logic            b_valid;
    logic [1:0]      b_resp;
    logic            b_ready;

    logic [AW-1:0]   ar_addr;
    logic            ar_valid;
    logic            ar_ready;
    logic [XLEN-1:0] r_data;
    logic [1:0]      r_resp;
    logic            r_valid;
    logic            r_ready;

    // The LSU side drives the bus; the slave side is the core plus interconnect.
    modport master (
        input  req_valid, req_store, req_func3, req_addr, req_wdata, req_rd,
        output req_ready,
        output resp_valid, resp_data, resp_rd, resp_err,
        input  resp_ready,
        output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
        input  aw_ready, w_ready, b_valid, b_resp,
        output ar_addr, ar_valid, r_ready,
        input  ar_ready, r_data, r_resp, r_valid
    );

    modport slave (
        output req_valid, req_store, req_func3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  resp_valid, resp_data, resp_rd, resp_err,
        output resp_ready,
        input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
        output aw_ready, w_ready, b_valid, b_resp,
        input  ar_addr, ar_valid, r_ready,
        output ar_ready, r_data, r_resp, r_valid
    );

endinterface

`default_nettype wire

// File: rtl/exu_lsu_axi_lane_align.sv
// ============================================================================
//  Module   : lsu_lane_align
//  Brief    : Byte-lane steering, strobes, misalignment and load extension.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter  int XLEN = 64,
    localparam int NB   = XLEN / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  wire logic [1:0]      size_i,
    input  wire logic [OFFW-1:0] off_i,
    input  wire logic            unsigned_i,
    input  wire logic [XLEN-1:0] wdata_i,
    input  wire logic [XLEN-1:0] rdata_i,
    output logic      [NB-1:0]   strb_o,
    output logic      [XLEN-1:0] wdata_sh_o,
    output logic                 misalign_o,
    output logic      [XLEN-1:0] rdata_ext_o
);

    logic [3:0]      w_nbytes;
    logic [NB-1:0]   w_strb_base;
    logic [XLEN-1:0] w_rsh;
    logic [XLEN-1:0] w_top;
    int              w_sa;

    always_comb begin
        w_nbytes    = 4'd1 << size_i;
        w_strb_base = '1;
        w_rsh       = rdata_i >> {off_i, 3'b000};
        w_top       = '0;
        w_sa        = 0;
        rdata_ext_o = w_rsh;

        case (size_i)
            SZ_B:    w_strb_base = NB'(1);
            SZ_H:    w_strb_base = NB'(3);
            SZ_W:    w_strb_base = NB'(15);
            default: w_strb_base = '1;
        endcase

        strb_o     = w_strb_base << off_i;
        wdata_sh_o = wdata_i << {off_i, 3'b000};
        misalign_o = (int'(w_nbytes) > NB) || ((off_i & OFFW'(w_nbytes - 4'd1)) != '0);

        // Park the loaded field at the top, then shift back to extend it.
        if (int'(w_nbytes) < NB) begin
            w_sa        = XLEN - 8 * int'(w_nbytes);
            w_top       = w_rsh << w_sa;
            rdata_ext_o = unsigned_i ? (w_top >> w_sa)
                                     : $unsigned($signed(w_top) >>> w_sa);
        end
    end

endmodule

`default_nettype wire

// File: rtl/exu_lsu_axi.sv
// ============================================================================
//  Module   : exu_lsu_axi
//  Brief    : Single-outstanding load/store unit issuing one-beat AXI bursts.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module exu_lsu_axi
    import lsu_pkg::*;
#(
    parameter  int XLEN = 64,
    parameter  int AW   = 64,
    localparam int NB   = XLEN / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    exu_lsu_axi_if.master lsu_bus
);

    lsu_state_e      state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [OFFW-1:0] off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [NB-1:0]   strb_q, strb_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [4:0]      rd_q, rd_d;
    logic [1:0]      err_q, err_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;

    logic [1:0]      w_size;
    logic [OFFW-1:0] w_off;
    logic [NB-1:0]   w_strb;
    logic [XLEN-1:0] w_wdata_sh;
    logic            w_misalign;
    logic [XLEN-1:0] w_rdata_ext;

    // One aligner serves the incoming request in IDLE and the held request afterwards.
    assign w_size = (state_q == ST_IDLE) ? lsu_bus.req_func3[1:0]      : size_q;
    assign w_off  = (state_q == ST_IDLE) ? lsu_bus.req_addr[OFFW-1:0] : off_q;

    lsu_lane_align #(.XLEN(XLEN)) u_lane_align (
        .size_i      (w_size),
        .off_i       (w_off),
        .unsigned_i  (uns_q),
        .wdata_i     (lsu_bus.req_wdata),
        .rdata_i     (lsu_bus.r_data),
        .strb_o      (w_strb),
        .wdata_sh_o  (w_wdata_sh),
        .misalign_o  (w_misalign),
        .rdata_ext_o (w_rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            off_q     <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
            rd_q      <= '0;
            err_q     <= LSU_OK;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            off_q     <= off_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            rdata_q   <= rdata_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        off_d     = off_q;
        size_d    = size_q;
        uns_d     = uns_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        rdata_d   = rdata_q;
        rd_d      = rd_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        case (state_q)
            ST_IDLE: begin
                if (lsu_bus.req_valid) begin
                    addr_d    = {lsu_bus.req_addr[AW-1:OFFW], {OFFW{1'b0}}};
                    off_d     = lsu_bus.req_addr[OFFW-1:0];
                    size_d    = lsu_bus.req_func3[1:0];
                    uns_d     = lsu_bus.req_func3[2];
                    wdata_d   = w_wdata_sh;
                    strb_d    = w_strb;
                    rdata_d   = '0;
                    rd_d      = lsu_bus.req_rd;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (w_misalign) begin
                        err_d   = LSU_MISALIGN;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = LSU_OK;
                        state_d = lsu_bus.req_store ? ST_WR_REQ : ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (lsu_bus.ar_ready) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (lsu_bus.r_valid) begin
                    rdata_d = w_rdata_ext;
                    err_d   = (lsu_bus.r_resp != 2'd0) ? LSU_BUSERR : LSU_OK;
                    state_d = ST_RESP;
                end
            end
            ST_WR_REQ: begin
                aw_done_d = aw_done_q | lsu_bus.aw_ready;
                w_done_d  = w_done_q  | lsu_bus.w_ready;
                if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (lsu_bus.b_valid) begin
                    err_d   = (lsu_bus.b_resp != 2'd0) ? LSU_BUSERR : LSU_OK;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (lsu_bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Every output decodes flops only, so request inputs never reach the bus combinationally.
    assign lsu_bus.req_ready  = (state_q == ST_IDLE);
    assign lsu_bus.ar_valid   = (state_q == ST_RD_ADDR);
    assign lsu_bus.r_ready    = (state_q == ST_RD_DATA);
    assign lsu_bus.aw_valid   = (state_q == ST_WR_REQ) && !aw_done_q;
    assign lsu_bus.w_valid    = (state_q == ST_WR_REQ) && !w_done_q;
    assign lsu_bus.b_ready    = (state_q == ST_WR_RESP);
    assign lsu_bus.resp_valid = (state_q == ST_RESP);
    assign lsu_bus.aw_addr    = addr_q;
    assign lsu_bus.ar_addr    = addr_q;
    assign lsu_bus.w_data     = wdata_q;
    assign lsu_bus.w_strb     = strb_q;
    assign lsu_bus.resp_data  = rdata_q;
    assign lsu_bus.resp_rd    = rd_q;
    assign lsu_bus.resp_err   = err_q;

endmodule

`default_nettype wire

// File: doc/exu_lsu_axi.md
# exu_lsu_axi

Parametrised load/store unit for the EXU, generalised from the fixed 64-bit memory path. It accepts one load or store per request on a valid/ready interface and issues a single-beat AXI-style transaction. It applies address-offset byte lanes and strobes, and detects misalignment without touching the bus. It returns sign- or zero-extended load data, or a store completion, on a held response handshake toward writeback.

## Interface
Parameters:
- `XLEN`, 64: register and bus data width in bits; must be 32 or 64.
- `AW`, 64: address width in bits.
- `NB`, derived as `XLEN/8`: bytes per beat.
- `OFFW`, derived as `$clog2(NB)`: width of the byte-offset field.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_store`  in  1  1 selects store, 0 selects load.
- `req_func3`  in  3  RISC-V funct3. Size is `[1:0]` (00 byte, 01 half, 10 word, 11 double). Bit 2 selects unsigned load.
- `req_addr`  in  AW  effective byte address.
- `req_wdata`  in  XLEN  store data, LSB-aligned.
- `req_rd`  in  5  destination register tag.
- `resp_valid`  out  1  result present.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_data`  out  XLEN  extended load data; 0 for stores.
- `resp_rd`  out  5  tag copied from the request.
- `resp_err`  out  2  error code: 0 ok, 1 misaligned, 2 bus error.
- `aw_addr` out AW, `aw_valid` out 1, `aw_ready` in 1: write address channel.
- `w_data` out XLEN, `w_strb` out NB, `w_valid` out 1, `w_ready` in 1: write data channel.
- `b_valid` in 1, `b_resp` in 2, `b_ready` out 1: write response channel.
- `ar_addr` out AW, `ar_valid` out 1, `ar_ready` in 1: read address channel.
- `r_data` in XLEN, `r_resp` in 2, `r_valid` in 1, `r_ready` out 1: read data channel.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE: `req_ready`=1. On `req_valid`, register the request and check alignment.
  - Misaligned means `addr % (1<<size) != 0`, or size 11 when XLEN=32. A misaligned request goes to RESP with `resp_err`=1 and no bus activity.
  - An aligned load goes to RD_ADDR.
  - An aligned store goes to WR_REQ.
- Bus address is `{addr[AW-1:OFFW], OFFW'b0}`. The offset `off` is `addr[OFFW-1:0]`.
- Store lanes:
  - `w_strb` = `((1<<(1<<size))-1) << off`.
  - `w_data` = `req_wdata << (8*off)`. Bits outside the strobe are don't-care but deterministic: the shifted value.
- RD_ADDR: `ar_valid`=1 until `ar_ready`, then go to RD_DATA.
- RD_DATA: `r_ready`=1. On `r_valid`:
  - Shift `r_data` right by `8*off`.
  - Truncate to size, then sign-extend, or zero-extend if `func3[2]`=1.
  - Latch the result, set `resp_err` to 2 if `r_resp != 0`, and go to RESP.
- WR_REQ: `aw_valid` and `w_valid` assert together.
  - Each deasserts independently after its own handshake, tracked by `aw_done`/`w_done` flags.
  - When both handshakes are done (same or different cycles), go to WR_RESP.
- WR_RESP: `b_ready`=1. On `b_valid`, set `resp_err` to 2 if `b_resp != 0`, and go to RESP.
- RESP: `resp_valid`=1 and all response fields are held stable until `resp_ready`, then return to IDLE.
- Signed loads at size 11, or size 10 when XLEN=32, pass through unextended.

## Timing
- Reset (async assert, sync-safe deassert):
  - State is IDLE.
  - `req_ready`=1.
  - All `*_valid`, `b_ready`, `r_ready`, `resp_valid` are 0.
  - `resp_data`, `resp_rd`, `resp_err`, `aw_addr`, `ar_addr`, `w_data`, `w_strb` are 0.
- Reset mid-transaction: the unit drops to IDLE immediately and abandons any outstanding channel. The interconnect is reset with the core.
- All bus and response outputs are registered. There is no combinational path from request inputs to any output.
- Accept at cycle 0 gives `ar_valid` at cycle 1. With zero-wait `ar_ready` and `r_valid` arriving at cycle 2, `resp_valid` is at cycle 3. Minimum load latency is 3 cycles.
- Minimum store latency is 3 cycles: `aw`/`w` at cycle 1, `b` at cycle 2, `resp` at cycle 3.
- A misaligned request gets `resp_valid` at cycle 1.
- Throughput is one request in flight. `req_ready` stays 0 from the cycle after acceptance until the cycle after the response handshake.
- `ar_valid`, `aw_valid` and `w_valid`, once asserted, never drop before their ready.
- Stray `r_valid` or `b_valid` outside RD_DATA/WR_RESP is ignored, because the ready signals are low.

## Structure
- Package `lsu_pkg` holds:
  - the `lsu_state_e` enum;
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`;
  - error codes `LSU_OK`, `LSU_MISALIGN`, `LSU_BUSERR`.
- One combinational sub-module, `lsu_lane_align`, parametrised by XLEN. Given `size`, `off`, `unsigned`, `wdata` and `rdata`, it produces `strb`, `wdata_sh`, `misalign` and `rdata_ext`. The FSM wrapper holds all state.

## Test plan
- XLEN=64, store byte (func3 000) at 0x80000003, wdata 0xAB: expect `aw_addr` 0x80000000, `w_strb` 0x08, `w_data[31:24]` 0xAB, and `resp_err` 0 after `b_resp` 0.
- Load half signed (001) at 0x80000006, `r_data` 0x8001_0000_0000_0000: expect `resp_data` 0xFFFF_FFFF_FFFF_8001. Repeat as lhu (101): expect 0x0000_0000_0000_8001.
- Load word (010) at 0x80000002: expect `resp_valid` and `resp_err`=1 at cycle 1, and `ar_valid` never asserted.
- Store double with `w_ready` held low for 4 cycles while `aw_ready`=1 immediately: expect `aw_valid` to fall after 1 cycle, `w_valid` to stay high until its handshake, then `b_ready`.
- Load double with `r_resp`=2 and `resp_ready` low for 3 cycles: expect `resp_err`=2 and `resp_data`/`resp_rd` stable throughout, with `req_ready`=1 one cycle after the handshake.
- Assert `rst_n`=0 while in RD_DATA: expect `r_ready`=0 and `req_ready`=1 asynchronously. A following aligned load then completes normally.
